// File: rtl/addsub_pipe_nbit.sv
// Pipelined signed add/subtract with a chunked carry chain and valid/ready handshake.
// Define ADDSUB_OVF_EN to add the registered ovf output.
module addsub_pipe_nbit #(
  parameter int unsigned n      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n:0]   sum
`ifdef ADDSUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned W = n / STAGES;

  logic [STAGES-1:0] r_vld;
  logic              w_adv;
  logic [n-1:0]      w_bx;

  // Global stall: every stage moves together or holds together.
  assign w_adv     = ~r_vld[STAGES-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign w_bx      = b ^ {n{op}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= STAGES'({r_vld, in_valid});
    end
  end

  // Stage k adds chunk k; unconsumed upper operand bits and finished lower sums ride along.
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_st
    localparam int unsigned RW = n - W * k;

    logic [RW-1:0]        w_ah;
    logic [RW-1:0]        w_bh;
    logic                 w_c;
    logic [W:0]           w_add;
    logic [(k+1)*W-1:0]   w_pl;

    if (k == 0) begin : g_src
      assign w_ah = a;
      assign w_bh = w_bx;
      assign w_c  = op;
      assign w_pl = w_add[W-1:0];
    end else begin : g_src
      assign w_ah = g_st[k-1].g_reg.r_ah;
      assign w_bh = g_st[k-1].g_reg.r_bh;
      assign w_c  = g_st[k-1].g_reg.r_c;
      assign w_pl = {w_add[W-1:0], g_st[k-1].g_reg.r_pl};
    end

    assign w_add = (W+1)'(w_ah[W-1:0]) + (W+1)'(w_bh[W-1:0]) + (W+1)'(w_c);

    if (k < int'(STAGES) - 1) begin : g_reg
      logic [RW-W-1:0]      r_ah;
      logic [RW-W-1:0]      r_bh;
      logic [(k+1)*W-1:0]   r_pl;
      logic                 r_c;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ah <= '0;
          r_bh <= '0;
          r_pl <= '0;
          r_c  <= 1'b0;
        end else if (w_adv) begin
          r_ah <= w_ah[RW-1:W];
          r_bh <= w_bh[RW-1:W];
          r_pl <= w_pl;
          r_c  <= w_add[W];
        end
      end
    end else begin : g_out
      logic w_msb;

      // Sign of the exact result: bx is never negated in n bits, so this holds for -2^(n-1) too.
      assign w_msb = w_ah[RW-1] ^ w_bh[RW-1] ^ w_add[W];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum <= '0;
`ifdef ADDSUB_OVF_EN
          ovf <= 1'b0;
`endif
        end else if (w_adv) begin
          sum <= {w_msb, w_pl};
`ifdef ADDSUB_OVF_EN
          ovf <= w_msb ^ w_pl[n-1];
`endif
        end
      end
    end
  end

endmodule
